// File: rtl/regfile_2w4r.sv
// regfile_2w4r
//   32 x DATA_W register file with two write lanes and four read ports.
//   Lane A is the older instruction and lane B the younger one, so whenever
//   both lanes target the same register, lane B's data is what remains.
//
//   A lane performs an effective write when RegWrite=1 and WriteReg!=0.
//   Register 0 is hardwired to zero. It is never written, and every read
//   of address 0 returns zero.
//
//   Reads are combinational. A read of a register that is being written
//   in the current cycle returns the incoming Result (bypass), with lane B
//   taking precedence. The read value is therefore always the value the
//   register holds after the next edge.
//
//   WriteCount accumulates the number of effective writes (0, 1 or 2 per
//   edge) and wraps modulo 2^CNT_W.
//
// Ports
//   clk                      rising-edge clock
//   reset                    synchronous active-high reset; clears storage
//                            and WriteCount, drops writes, zeroes reads
//   RegWriteA/B              lane write enables
//   WriteRegA/B [4:0]        lane destination registers
//   ResultA/B [DATA_W-1:0]   lane write data
//   RsA, RtA, RsB, RtB       read addresses
//   RdRsA..RdRtB             read data for the matching address
//   WriteCount [CNT_W-1:0]   running count of effective writes
module regfile_2w4r #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteA,
    input  logic              RegWriteB,
    input  logic [4:0]        WriteRegA,
    input  logic [4:0]        WriteRegB,
    input  logic [DATA_W-1:0] ResultA,
    input  logic [DATA_W-1:0] ResultB,
    input  logic [4:0]        RsA,
    input  logic [4:0]        RtA,
    input  logic [4:0]        RsB,
    input  logic [4:0]        RtB,
    output logic [DATA_W-1:0] RdRsA,
    output logic [DATA_W-1:0] RdRtA,
    output logic [DATA_W-1:0] RdRsB,
    output logic [DATA_W-1:0] RdRtB,
    output logic [CNT_W-1:0]  WriteCount
);

    logic [DATA_W-1:0] regs [32];

    // A write to r0 is not a write: it neither lands nor counts.
    logic wea;
    logic web;
    assign wea = RegWriteA && (WriteRegA != 5'd0);
    assign web = RegWriteB && (WriteRegB != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            WriteCount <= '0;
        end else begin
            // B is assigned last, so on a same-address collision it wins.
            if (wea) begin
                regs[WriteRegA] <= ResultA;
            end
            if (web) begin
                regs[WriteRegB] <= ResultB;
            end
            WriteCount <= WriteCount + CNT_W'(wea) + CNT_W'(web);
        end
    end

    // The four read ports are identical. Each one is indexed here so that
    // the bypass priority is written once.
    logic [4:0]        raddr [4];
    logic [DATA_W-1:0] rdata [4];

    assign raddr[0] = RsA;
    assign raddr[1] = RtA;
    assign raddr[2] = RsB;
    assign raddr[3] = RtB;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = '0;
            if (!reset && (raddr[p] != 5'd0)) begin
                if (web && (raddr[p] == WriteRegB)) begin
                    rdata[p] = ResultB;
                end else if (wea && (raddr[p] == WriteRegA)) begin
                    rdata[p] = ResultA;
                end else begin
                    rdata[p] = regs[raddr[p]];
                end
            end
        end
    end

    assign RdRsA = rdata[0];
    assign RdRtA = rdata[1];
    assign RdRsB = rdata[2];
    assign RdRtB = rdata[3];

endmodule

// File: tb/tb_regfile_2w4r.sv
// Testbench for regfile_2w4r.
//
// Two instances share every input. The main one uses the default widths.
// The second one uses a 3-bit WriteCount, so that wrap-around is reached
// after only a handful of writes.
module tb_regfile_2w4r;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          RegWriteA, RegWriteB;
  logic [4:0]    WriteRegA, WriteRegB;
  logic [DW-1:0] ResultA, ResultB;
  logic [4:0]    RsA, RtA, RsB, RtB;
  logic [DW-1:0] RdRsA, RdRtA, RdRsB, RdRtB;
  logic [CW-1:0] WriteCount;
  logic [DW-1:0] s_rdrsa, s_rdrta, s_rdrsb, s_rdrtb;
  logic [SW-1:0] s_cnt;

  regfile_2w4r #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RegWriteA(RegWriteA), .RegWriteB(RegWriteB),
    .WriteRegA(WriteRegA), .WriteRegB(WriteRegB),
    .ResultA(ResultA), .ResultB(ResultB),
    .RsA(RsA), .RtA(RtA), .RsB(RsB), .RtB(RtB),
    .RdRsA(RdRsA), .RdRtA(RdRtA), .RdRsB(RdRsB), .RdRtB(RdRtB),
    .WriteCount(WriteCount)
  );

  regfile_2w4r #(.DATA_W(DW), .CNT_W(SW)) dut_s (
    .clk(clk), .reset(reset),
    .RegWriteA(RegWriteA), .RegWriteB(RegWriteB),
    .WriteRegA(WriteRegA), .WriteRegB(WriteRegB),
    .ResultA(ResultA), .ResultB(ResultB),
    .RsA(RsA), .RtA(RtA), .RsB(RsB), .RtB(RtB),
    .RdRsA(s_rdrsa), .RdRtA(s_rdrta), .RdRsB(s_rdrsb), .RdRtB(s_rdrtb),
    .WriteCount(s_cnt)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic          rst;
    logic          wea;
    logic [4:0]    wra;
    logic [DW-1:0] da;
    logic          web;
    logic [4:0]    wrb;
    logic [DW-1:0] db;
    logic [4:0]    rsa, rta, rsb, rtb;
    logic [DW-1:0] e_rsa, e_rta, e_rsb, e_rtb;  // reads before the edge
    logic [CW-1:0] e_cnt;                       // count after the edge
  } vec_t;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    reset     = v.rst;
    RegWriteA = v.wea; WriteRegA = v.wra; ResultA = v.da;
    RegWriteB = v.web; WriteRegB = v.wrb; ResultB = v.db;
    RsA = v.rsa; RtA = v.rta; RsB = v.rsb; RtB = v.rtb;
  endtask

  // Inputs change at the negedge. The combinational reads are sampled 1
  // time unit later. The counts are sampled 1 time unit after the
  // following posedge.
  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, ".rdrsa"}, RdRsA, v.e_rsa);
    chk({name, ".rdrta"}, RdRta_w(), v.e_rta);
    chk({name, ".rdrsb"}, RdRsB, v.e_rsb);
    chk({name, ".rdrtb"}, RdRtB, v.e_rtb);
    @(posedge clk);
    #1;
    chk({name, ".cnt"}, WriteCount, v.e_cnt);
    chk({name, ".scnt"}, {29'd0, s_cnt}, {29'd0, v.e_cnt[SW-1:0]});
  endtask

  function automatic logic [DW-1:0] RdRta_w();
    return RdRtA;
  endfunction

  function automatic vec_t mk(input logic rst, input logic wea,
      input logic [4:0] wra, input logic [DW-1:0] da, input logic web,
      input logic [4:0] wrb, input logic [DW-1:0] db,
      input logic [4:0] rsa, input logic [4:0] rta,
      input logic [4:0] rsb, input logic [4:0] rtb,
      input logic [DW-1:0] e0, input logic [DW-1:0] e1,
      input logic [DW-1:0] e2, input logic [DW-1:0] e3,
      input logic [CW-1:0] ec);
    vec_t v;
    v.rst = rst; v.wea = wea; v.wra = wra; v.da = da;
    v.web = web; v.wrb = wrb; v.db = db;
    v.rsa = rsa; v.rta = rta; v.rsb = rsb; v.rtb = rtb;
    v.e_rsa = e0; v.e_rta = e1; v.e_rsb = e2; v.e_rtb = e3;
    v.e_cnt = ec;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // After each edge the register file holds the old contents with every
  // effective write applied in program order (A, then B). A read returns
  // the contents as they will be after the edge, or zero during reset.
  logic [DW-1:0] mem [32];
  logic [CW-1:0] mcnt;

  task automatic model_step(inout vec_t v);
    logic [DW-1:0] nxt [32];
    int n;
    nxt = mem;
    n = 0;
    if (v.wea && v.wra != 0) begin nxt[v.wra] = v.da; n++; end
    if (v.web && v.wrb != 0) begin nxt[v.wrb] = v.db; n++; end
    v.e_rsa = v.rst ? '0 : nxt[v.rsa];
    v.e_rta = v.rst ? '0 : nxt[v.rta];
    v.e_rsb = v.rst ? '0 : nxt[v.rsb];
    v.e_rtb = v.rst ? '0 : nxt[v.rtb];
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      mcnt = '0;
    end else begin
      mem  = nxt;
      mcnt = mcnt + CW'(n);
    end
    v.e_cnt = mcnt;
  endtask

  // ---------------- test ----------------
  vec_t tbl [12];

  initial begin
    vec_t v;

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Directed table.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 3, 31, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, 5, 0, 5, 6,
                 32'h1111_1111, 0, 32'h1111_1111, 32'h2222_2222, 2);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 6, 6, 5,
                 32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 2);
    tbl[3]  = mk(0, 1, 7, 32'hAAAA_0000, 1, 7, 32'hBBBB_0000, 7, 7, 7, 7,
                 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 4);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7,
                 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0000, 4);
    tbl[5]  = mk(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 5, 0, 7,
                 0, 32'h1111_1111, 0, 32'hBBBB_0000, 4);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 6,
                 0, 32'hBBBB_0000, 0, 32'h2222_2222, 4);
    tbl[7]  = mk(0, 1, 3, 32'h0000_0003, 0, 0, 0, 3, 3, 5, 0,
                 32'h0000_0003, 32'h0000_0003, 32'h1111_1111, 0, 5);
    tbl[8]  = mk(1, 0, 0, 0, 1, 3, 32'h0000_0099, 5, 7, 3, 6, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 5, 6, 7, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 8, 32'h55, 1, 9, 32'h77, 8, 9, 0, 9,
                 0, 32'h77, 0, 32'h77, 1);
    tbl[11] = mk(0, 1, 9, 32'h1, 1, 10, 32'h2, 9, 10, 9, 10,
                 32'h1, 32'h2, 32'h1, 32'h2, 3);

    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Count wrap: reset, 7 single writes, then one dual write.
    // The 3-bit counter goes 7 -> 1 and the 32-bit counter goes 7 -> 9.
    apply_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap_rst");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(mk(0, 1, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    chk("wrap.pre_s", {29'd0, s_cnt}, 32'd7);
    chk("wrap.pre", WriteCount, 32'd7);
    @(negedge clk);
    drive(mk(0, 1, 11, 32'h1, 1, 12, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("wrap.post_s", {29'd0, s_cnt}, 32'd1);
    chk("wrap.post", WriteCount, 32'd9);

    // Randomized phase against the reference model. The first cycle is a
    // reset, so the model and the DUT start from the same state. Writes
    // are kept to a few low registers to provoke collisions and bypasses.
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mcnt = '0;
    for (int c = 0; c < 400; c++) begin
      v.rst = (c == 0) || ($urandom_range(0, 19) == 0);
      v.wea = $urandom_range(0, 3) != 0;
      v.web = $urandom_range(0, 3) != 0;
      v.wra = 5'($urandom_range(0, 7));
      v.wrb = ($urandom_range(0, 3) == 0) ? v.wra : 5'($urandom_range(0, 7));
      v.da  = $urandom;
      v.db  = $urandom;
      v.rsa = ($urandom_range(0, 2) == 0) ? v.wra : 5'($urandom_range(0, 9));
      v.rta = ($urandom_range(0, 2) == 0) ? v.wrb : 5'($urandom_range(0, 9));
      v.rsb = 5'($urandom_range(0, 31));
      v.rtb = ($urandom_range(0, 3) == 0) ? v.rsa : 5'($urandom_range(0, 9));
      model_step(v);
      apply_vec(v, $sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
